// File: rtl/ex_mem_skid_stage.sv
// rtl/ex_mem_skid_stage.sv - EX->MEM pipeline stage with 2-entry skid buffer
// Optional stall counter port enabled by defining EX_MEM_STALL_CNT_EN.
module ex_mem_skid_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_write_data,
  input  logic [REG_W-1:0]  in_write_reg,
  input  logic              in_zero,
  input  logic [DATA_W-1:0] in_branch_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_write_data,
  output logic [REG_W-1:0]  out_write_reg,
  output logic              out_zero,
  output logic [DATA_W-1:0] out_branch_addr,
`ifdef EX_MEM_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              out_branch_taken
);

  localparam int PW = CTRL_W + 3 * DATA_W + REG_W + 1;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   main_q, skid_q, in_pay;
  logic            acc, drn;
  logic            load_main, load_skid, shift_skid;

  assign in_pay = {in_ctrl, in_alu_result, in_write_data, in_write_reg, in_zero, in_branch_addr};
  assign acc    = in_valid & in_ready;
  assign drn    = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (acc) state_nxt = ONE;
      ONE:     if (drn && !acc) state_nxt = EMPTY;
               else if (acc && !drn) state_nxt = FULL;
      FULL:    if (drn) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end

  // Ready and valid come from the registered state only, so no comb path crosses the stage.
  always_comb begin
    in_ready   = (state != FULL);
    out_valid  = (state != EMPTY);
    load_main  = 1'b0;
    load_skid  = 1'b0;
    shift_skid = 1'b0;
    case (state)
      EMPTY:   load_main = acc;
      ONE: begin
        load_main = acc & drn;
        load_skid = acc & ~drn;
      end
      FULL:    shift_skid = drn;
      default: ;
    endcase
  end

  // Flush only clears state; payload may keep stale data, masked by out_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)       main_q <= in_pay;
      else if (shift_skid) main_q <= skid_q;
      if (load_skid)       skid_q <= in_pay;
    end
  end

  assign {out_ctrl, out_alu_result, out_write_data, out_write_reg, out_zero, out_branch_addr} = main_q;
  assign out_branch_taken = out_valid & out_ctrl[2] & out_zero;

`ifdef EX_MEM_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= 16'h0;
    else if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'h1;
  end
`endif

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// tb/tb_ex_mem_skid_stage.sv - directed self-checking bench for ex_mem_skid_stage
module tb_ex_mem_skid_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]  in_ctrl, out_ctrl;
  logic [31:0] in_alu_result, in_write_data, in_branch_addr;
  logic [31:0] out_alu_result, out_write_data, out_branch_addr;
  logic [4:0]  in_write_reg, out_write_reg;
  logic        in_zero, out_zero, out_branch_taken;
`ifdef EX_MEM_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_mem_skid_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_alu_result(in_alu_result), .in_write_data(in_write_data),
    .in_write_reg(in_write_reg), .in_zero(in_zero), .in_branch_addr(in_branch_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_alu_result(out_alu_result), .out_write_data(out_write_data),
    .out_write_reg(out_write_reg), .out_zero(out_zero), .out_branch_addr(out_branch_addr),
`ifdef EX_MEM_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .out_branch_taken(out_branch_taken)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] ctrl,
                       input logic z, input logic [31:0] baddr);
    in_valid       = v;
    in_alu_result  = alu;
    in_write_data  = alu ^ 32'hFFFF_0000;
    in_write_reg   = alu[4:0];
    in_ctrl        = ctrl;
    in_zero        = z;
    in_branch_addr = baddr;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 5'h0, 1'b0, 32'h0);
    tick(); tick();
    check("rst_ov",  out_valid, 0);
    check("rst_ir",  in_ready, 1);
    check("rst_alu", out_alu_result, 0);
    check("rst_bt",  out_branch_taken, 0);
    reset = 1'b0;

    // single entry, 1-cycle latency
    drive(1'b1, 32'h10, 5'b00001, 1'b0, 32'h0);
    in_write_reg = 5'd3;
    tick();
    check("one_ov",  out_valid, 1);
    check("one_alu", out_alu_result, 32'h10);
    check("one_reg", out_write_reg, 3);
    check("one_ctl", out_ctrl, 5'b00001);
    in_valid = 1'b0;
    tick();
    check("one_ov0", out_valid, 0);

    // back-to-back streaming
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h100 + i, 5'b00001, 1'b0, 32'h0);
      check("str_ir", in_ready, 1);
      tick();
      check("str_ov",  out_valid, 1);
      check("str_alu", out_alu_result, 32'h100 + i);
      check("str_wd",  out_write_data, (32'h100 + i) ^ 32'hFFFF_0000);
    end
    in_valid = 1'b0;
    tick();
    check("str_end", out_valid, 0);

    // backpressure fills the skid, then drains in order
    out_ready = 1'b0;
    drive(1'b1, 32'hA0, 5'b00011, 1'b0, 32'h0);
    tick();
    check("bp_a_ir", in_ready, 1);
    drive(1'b1, 32'hB0, 5'b00011, 1'b0, 32'h0);
    tick();
    check("bp_full", in_ready, 0);
    check("bp_outa", out_alu_result, 32'hA0);
    drive(1'b1, 32'hC0, 5'b00011, 1'b0, 32'h0);
    tick();
    check("bp_hold", out_alu_result, 32'hA0);
    check("bp_hir",  in_ready, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_outb", out_alu_result, 32'hB0);
    check("bp_bov",  out_valid, 1);
    check("bp_ir1",  in_ready, 1);
    tick();
    check("bp_emp",  out_valid, 0);

    // branch resolution, zero=0 then zero=1, then masked when idle
    drive(1'b1, 32'h20, 5'b00100, 1'b0, 32'h40);
    tick();
    check("br_nt",   out_branch_taken, 0);
    check("br_ntov", out_valid, 1);
    drive(1'b1, 32'h24, 5'b00100, 1'b1, 32'h40);
    tick();
    check("br_t",    out_branch_taken, 1);
    check("br_addr", out_branch_addr, 32'h40);
    in_valid = 1'b0;
    tick();
    check("br_mask", out_branch_taken, 0);

    // flush while FULL with a same-cycle accept attempt
    out_ready = 1'b0;
    drive(1'b1, 32'h51, 5'b00001, 1'b0, 32'h0); tick();
    drive(1'b1, 32'h52, 5'b00001, 1'b0, 32'h0); tick();
    check("fl_full", in_ready, 0);
    drive(1'b1, 32'h53, 5'b00001, 1'b0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_ov",  out_valid, 0);
    check("fl_ir",  in_ready, 1);
    tick();
    check("fl_ov2", out_valid, 0);
    out_ready = 1'b1;
    drive(1'b1, 32'h54, 5'b00001, 1'b0, 32'h0);
    tick();
    check("fl_next", out_alu_result, 32'h54);

    // flush while ONE and draining/accepting: accepted entry discarded
    drive(1'b1, 32'h55, 5'b00001, 1'b0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl1_ov", out_valid, 0);

    // reset asserted mid-stall takes effect without a clock edge
    out_ready = 1'b0;
    drive(1'b1, 32'h61, 5'b00101, 1'b1, 32'h99); tick();
    drive(1'b1, 32'h62, 5'b00101, 1'b1, 32'h99); tick();
    check("ms_bt", out_branch_taken, 1);
    #2 reset = 1'b1;
    #1;
    check("ar_ov",  out_valid, 0);
    check("ar_alu", out_alu_result, 0);
    check("ar_ba",  out_branch_addr, 0);
    check("ar_zr",  out_zero, 0);
    check("ar_bt",  out_branch_taken, 0);
    check("ar_ir",  in_ready, 1);
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("ar_ov2", out_valid, 0);

`ifdef EX_MEM_STALL_CNT_EN
    check("sc_rst", stall_cnt, 0);
    out_ready = 1'b0;
    drive(1'b1, 32'h70, 5'b00001, 1'b0, 32'h0);
    tick();
    in_valid = 1'b0;
    check("sc_0", stall_cnt, 0);
    for (int i = 0; i < 5; i++) tick();
    check("sc_5", stall_cnt, 5);
    for (int i = 0; i < 70000; i++) tick();
    check("sc_sat", stall_cnt, 16'hFFFF);
    flush = 1'b1; tick(); flush = 1'b0;
    tick();
    check("sc_fl", stall_cnt, 16'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
